fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 88 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencer with relative/absolute branches, call/return stack and halt
module fetch_unit #(
  parameter int PC_W      = 10,
  parameter int OFF_W     = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_rel_z,
  input  logic             branch_rel_nz,
  input  logic             branch_abs,
  input  logic             is_call,
  input  logic             is_ret,
  input  logic             halt,
  input  logic             zero_flag,
  input  logic [OFF_W-1:0] rel_offset,
  input  logic [PC_W-1:0]  abs_target,
  output logic [PC_W-1:0]  pc,
  output logic             instr_valid,
  output logic             done,
  output logic             ras_overflow,
  output logic             ras_underflow
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_nxt;
  logic [PC_W-1:0] pc_nxt, pc_inc, rel_tgt, ras_top;
  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic [AW:0] cnt;
  logic push, pop, ovf_set, unf_set, clr, full, empty, rel_take;
  assign pc_inc = pc + PC_W'(1);
  assign rel_tgt = pc + PC_W'($signed(rel_offset));
  assign full = cnt == FULL;
  assign empty = cnt == '0;
  assign ras_top = ras[AW'(cnt - ONE)];
  assign rel_take = (branch_rel_z && zero_flag) || (branch_rel_nz && !zero_flag);
  assign instr_valid = state == RUN && !stall;
  assign done = state == HALTED;
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    push = 1'b0;
    pop = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    clr = 1'b0;
    if (state != RUN) begin
      if (start) begin
        state_nxt = RUN;
        pc_nxt = '0;
        clr = 1'b1;
      end
    end else if (!stall) begin
      if (halt)
        state_nxt = HALTED;
      else if (branch_abs && is_ret) begin
        pc_nxt = empty ? pc_inc : ras_top;
        unf_set = empty;
        pop = !empty;
      end else if (branch_abs) begin
        pc_nxt = abs_target;
        push = is_call && !full;
        ovf_set = is_call && full;
      end else
        pc_nxt = rel_take ? rel_tgt : pc_inc;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      cnt <= '0;
      ras_overflow <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      cnt <= clr ? '0 : push ? cnt + ONE : pop ? cnt - ONE : cnt;
      ras_overflow <= !clr && (ras_overflow || ovf_set);
      ras_underflow <= !clr && (ras_underflow || unf_set);
      if (push) ras[AW'(cnt)] <= pc_inc;
    end
  end
endmodule
